// File: rtl/key_event_fifo.sv
// key_event_fifo: turns debounced one-hot key levels into press/auto-repeat
// events and queues them for the consumer over a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   RST          synchronous active-high reset
//   key_deb      debounced key levels, bit i = key i held
//   ev_ready     consumer takes the head event this cycle
//   ev_valid     FIFO holds at least one event
//   ev_code      head event key index
//   ev_repeat    head event is an auto-repeat
//   count        FIFO occupancy
//   overflow     sticky flag, an event was dropped on a full FIFO
//   clr_overflow clears overflow (a same-cycle set wins)

module key_event_fifo #(
    parameter int DEPTH        = 4,
    parameter bit REPEAT_EN    = 1'b1,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [15:0]              key_deb,
    input  logic                     ev_ready,
    output logic                     ev_valid,
    output logic [3:0]               ev_code,
    output logic                     ev_repeat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                        : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX);

    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_e;

    // Edge detection and press priority encoding
    logic [15:0] key_prev_q;
    logic [15:0] rise;
    logic        press;
    logic [3:0]  press_code;

    assign rise  = key_deb & ~key_prev_q;
    assign press = |rise;

    // Scan high-to-low so the lowest rising index is the one kept.
    always_comb begin
        press_code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (rise[i]) begin
                press_code = 4'(i);
            end
        end
    end

    // Repeat FSM
    state_e        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [3:0]    held_q, held_d;
    logic          held_key;
    logic          rep_fire;

    assign held_key = key_deb[held_q];

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            held_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        held_d  = held_q;
        if (REPEAT_EN && press) begin
            state_d = S_DELAY;
            rcnt_d  = '0;
            held_d  = press_code;
        end else begin
            case (state_q)
                S_DELAY: begin
                    if (!held_key) begin
                        state_d = S_IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == DLY_LAST) begin
                        state_d = S_REPEAT;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!held_key) begin
                        state_d = S_IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RATE_LAST) begin
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    // A fresh press in the same cycle suppresses the repeat.
    always_comb begin
        rep_fire = 1'b0;
        if (held_key && !press) begin
            if (state_q == S_DELAY && rcnt_q == DLY_LAST) begin
                rep_fire = 1'b1;
            end else if (state_q == S_REPEAT && rcnt_q == RATE_LAST) begin
                rep_fire = 1'b1;
            end
        end
    end

    // Event FIFO
    logic          ev_present;
    logic [4:0]    ev_data;
    logic [4:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    head_q, head_d;
    logic          ovf_q, ovf_d;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    assign ev_present = press | rep_fire;
    assign ev_data    = press ? {1'b0, press_code} : {1'b1, held_q};

    assign full = (count_q == FULL_CNT);
    assign pop  = ev_valid && ev_ready;
    assign push = ev_present && (!full || pop);
    assign drop = ev_present && full && !pop;

    always_comb begin
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // Registered head: bypass the write when it lands on the new head,
        // hold the last-read entry once the FIFO drains.
        head_d = head_q;
        if (count_d != '0) begin
            if (push && wr_q == rd_d) begin
                head_d = ev_data;
            end else begin
                head_d = mem_q[rd_d];
            end
        end
        ovf_d = drop | (ovf_q & ~clr_overflow);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 5'd0;
            end
        end else if (push) begin
            mem_q[wr_q] <= ev_data;
        end
    end

    // key_prev resets to all-ones so keys held across reset stay silent.
    always_ff @(posedge clk) begin
        if (RST) begin
            key_prev_q <= 16'hFFFF;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            head_q     <= 5'd0;
            ovf_q      <= 1'b0;
        end else begin
            key_prev_q <= key_deb;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            head_q     <= head_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ev_valid  = (count_q != '0);
    assign ev_code   = head_q[3:0];
    assign ev_repeat = head_q[4];
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// tb_key_event_fifo: scoreboard bench for key_event_fifo.
// Expected events are queued with the stimulus and checked on each pop.

module tb_key_event_fifo;

    logic        clk;
    logic        RST;
    logic [15:0] key_deb;
    logic        ev_ready;
    logic        ev_valid;
    logic [3:0]  ev_code;
    logic        ev_repeat;
    logic [2:0]  count;
    logic        overflow;
    logic        clr_overflow;

    int n_chk;
    int n_bad;
    logic [4:0] sb [$];

    key_event_fifo #(
        .DEPTH        (4),
        .REPEAT_EN    (1'b1),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .key_deb      (key_deb),
        .ev_ready     (ev_ready),
        .ev_valid     (ev_valid),
        .ev_code      (ev_code),
        .ev_repeat    (ev_repeat),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp_v);
        n_chk++;
        if (got != exp_v) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic rep, input int code);
        logic [3:0] c;
        c = 4'(code);
        sb.push_back({rep, c});
    endtask

    // Pop monitor: samples mid-cycle, the handshake completes at next edge.
    always @(negedge clk) begin
        logic [4:0] e;
        if (!RST && ev_valid && ev_ready) begin
            if (sb.size() == 0) begin
                chk("sb_under", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("pop_code", int'(ev_code), int'(e[3:0]));
                chk("pop_rep", int'(ev_repeat), int'(e[4]));
            end
        end
    end

    initial begin
        n_chk        = 0;
        n_bad        = 0;
        RST          = 1'b1;
        key_deb      = 16'h0000;
        ev_ready     = 1'b0;
        clr_overflow = 1'b0;
        step(2);
        RST = 1'b0;
        step(1);

        chk("rst_valid", ev_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_rep", ev_repeat, 0);

        // Single press of key 5 with consumer ready
        ev_ready = 1'b1;
        key_deb  = 16'h0020;
        push_exp(1'b0, 5);
        step(1);
        chk("t1_valid", ev_valid, 1);
        chk("t1_code", ev_code, 5);
        chk("t1_rep", ev_repeat, 0);
        key_deb = 16'h0000;
        step(1);
        chk("t1_count", count, 0);
        chk("t1_valid0", ev_valid, 0);
        chk("t1_hold", ev_code, 5);
        ev_ready = 1'b0;
        step(3);

        // Hold key 3: press at k, repeats at k+8, k+12, k+16, drop at k+20
        key_deb = 16'h0008;
        push_exp(1'b0, 3);
        push_exp(1'b1, 3);
        push_exp(1'b1, 3);
        push_exp(1'b1, 3);
        step(1);
        chk("t2_cnt_k", count, 1);
        step(7);
        chk("t2_cnt_k7", count, 1);
        step(1);
        chk("t2_cnt_k8", count, 2);
        step(4);
        chk("t2_cnt_k12", count, 3);
        step(4);
        chk("t2_cnt_k16", count, 4);
        step(3);
        chk("t2_ovf_k19", overflow, 0);
        step(1);
        chk("t2_ovf_k20", overflow, 1);
        chk("t2_cnt_k20", count, 4);
        key_deb      = 16'h0000;
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        chk("t2_clr", overflow, 0);
        step(10);
        chk("t2_norep", overflow, 0);
        ev_ready = 1'b1;
        step(4);
        ev_ready = 1'b0;
        chk("t2_drain", count, 0);

        // Keys 2 and 9 together: lowest wins, no overflow
        key_deb = 16'h0204;
        push_exp(1'b0, 2);
        step(1);
        chk("t3_count", count, 1);
        chk("t3_code", ev_code, 2);
        chk("t3_ovf", overflow, 0);
        key_deb = 16'h0000;
        step(1);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        step(3);
        chk("t3_count0", count, 0);

        // Five presses into a four-deep FIFO
        foreach (sb[i]) begin
            chk("t4_sb_pre", sb.size(), 0);
        end
        push_exp(1'b0, 1);
        push_exp(1'b0, 4);
        push_exp(1'b0, 6);
        push_exp(1'b0, 7);
        key_deb = 16'h0002;
        step(1);
        key_deb = 16'h0010;
        step(1);
        key_deb = 16'h0040;
        step(1);
        key_deb = 16'h0080;
        step(1);
        key_deb = 16'h0100;
        step(1);
        key_deb = 16'h0000;
        chk("t4_count", count, 4);
        chk("t4_ovf", overflow, 1);
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        chk("t4_clr", overflow, 0);

        // Full FIFO, pop and press of key 0 on the same edge
        push_exp(1'b0, 0);
        ev_ready = 1'b1;
        key_deb  = 16'h0001;
        step(1);
        key_deb = 16'h0000;
        chk("t5_count", count, 4);
        chk("t5_ovf", overflow, 0);
        step(4);
        ev_ready = 1'b0;
        chk("t5_drain", count, 0);
        chk("t5_valid", ev_valid, 0);
        chk("t5_hold", ev_code, 0);

        // Key 10 held across reset release
        RST     = 1'b1;
        key_deb = 16'h0400;
        step(2);
        RST = 1'b0;
        step(5);
        chk("t6_held_cnt", count, 0);
        step(10);
        chk("t6_held_rep", count, 0);
        key_deb = 16'h0000;
        step(2);

        // Reset mid-repeat with two queued entries
        key_deb = 16'h0800;
        step(9);
        chk("t6_q2", count, 2);
        chk("t6_q2_rep", ev_repeat, 0);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        chk("t6_rst_cnt", count, 0);
        chk("t6_rst_valid", ev_valid, 0);
        chk("t6_rst_code", ev_code, 0);
        step(20);
        chk("t6_norep", count, 0);
        key_deb = 16'h0000;
        step(2);

        chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/key_event_fifo.md
# key_event_fifo

Converts the debounced 16-bit one-hot key levels from `key_filter` into discrete press events. Each event carries a 4-bit key code plus a repeat flag; a held key generates auto-repeat events. Events are buffered in a small FIFO and handed to the game/decoder stage over a valid/ready handshake. It sits between `key_filter` and the code-entry logic, replacing level-sampled key handling with event-based, lossless-until-full input.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `REPEAT_EN`, 1: 1 enables auto-repeat; 0 forces the repeat FSM to stay in IDLE.
- `REPEAT_DELAY`, 25_000_000: cycles from press event to first repeat (0.5 s at 50 MHz); ≥2.
- `REPEAT_RATE`, 5_000_000: cycles between subsequent repeats; ≥2.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `RST`  in  1  reset; one clock, synchronous, active-high.
- `key_deb`  in  16  debounced key levels; bit i = key i held.
- `ev_ready`  in  1  consumer accepts the head event this cycle.
- `ev_valid`  out  1  FIFO non-empty.
- `ev_code`  out  4  head event key index.
- `ev_repeat`  out  1  head event is an auto-repeat (0 = fresh press).
- `count`  out  clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.
- `clr_overflow`  in  1  clears `overflow`.

## Operation
- Edge detect: register `key_prev <= key_deb`; `rise = key_deb & ~key_prev`.
- Multiple rising bits in one cycle: the lowest index wins. The others are discarded and do not set `overflow`.
- Press event: `{repeat=0, code}` whenever `rise != 0`.
- Repeat FSM, states IDLE / DELAY / REPEAT, with counter `rcnt` and register `held_code`:
  - On any press event, from any state: `held_code <= code`, `rcnt <= 0`, go to DELAY. A press of a new key while another is held retargets to the new key.
  - DELAY or REPEAT with `key_deb[held_code]==0`: go to IDLE, `rcnt <= 0`, no event.
  - DELAY with `rcnt == REPEAT_DELAY-1`: emit `{1, held_code}`, `rcnt <= 0`, go to REPEAT.
  - REPEAT with `rcnt == REPEAT_RATE-1`: emit `{1, held_code}`, `rcnt <= 0`.
  - Otherwise `rcnt` increments.
  - A press event and a repeat event in the same cycle: the press wins and the repeat is suppressed.
- FIFO: circular buffer with wr/rd pointers and `count`.
  - push = event present and (not full, or pop in the same cycle).
  - pop = `ev_valid && ev_ready`.
  - Push and pop together leave `count` unchanged. This also applies when full, where the push is accepted.
  - Event present, full, and no pop: the event is dropped and `overflow <= 1`.
- `ev_code`/`ev_repeat` are the head entry read from registered storage. When empty they hold the last-read entry's value; consumers qualify them with `ev_valid`.
- `overflow`: a set and `clr_overflow` in the same cycle leave it at 1 (set wins).
- Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `ev_valid=0`, `count=0`, `overflow=0`, `ev_code=0`, `ev_repeat=0`.
  - FIFO storage is cleared to 0.
  - FSM is in IDLE with `rcnt=0`, `held_code=0`.
  - `key_prev=16'hFFFF`, so keys held across reset release produce no event until released and re-pressed.
- `RST` during any operation discards FIFO contents and the FSM state. Outputs take their reset values after the next rising edge.
- Latency:
  - If `key_deb[i]` rises before edge k, the event is written at edge k and `ev_valid`/`ev_code=i` are visible after edge k (1 cycle).
  - If the FIFO was non-empty, the event appears once earlier entries have popped.
- Pop: the head advances at the edge where `ev_valid && ev_ready`. Next entry is visible the following cycle, so back-to-back pops are allowed.
- Repeat timing, for a press event written at edge k:
  - first repeat written at edge k+REPEAT_DELAY;
  - then at every further REPEAT_RATE edges.
- Release is detected on the first cycle `key_deb[held_code]==0`; no repeat is written at or after that edge.

## Test plan
Benches use `DEPTH=4`, `REPEAT_DELAY=8`, `REPEAT_RATE=4`.
- Single press of key 5, `ev_ready=1` → after the rise edge, `ev_valid=1`, `ev_code=5`, `ev_repeat=0` for one cycle; `count` returns to 0.
- Hold key 3 for 20 cycles after press edge k, `ev_ready=0` → FIFO holds codes 3/3/3/3 with repeat flags 0,1,1,1 (writes at k, k+8, k+12, k+16). A write at k+20 sets `overflow`. Releasing the key stops repeats.
- Keys 2 and 9 rise in the same cycle → exactly one event, code 2; `overflow` stays 0.
- `ev_ready=0`, presses of 1,4,6,7,8 on separate cycles → `count=4`, `overflow=1`; draining yields 1,4,6,7. `clr_overflow` pulse → `overflow=0`.
- FIFO full, `ev_ready=1` and a new press (key 0) on the same edge → push accepted, `count` stays 4, `overflow=0`; key 0 is the last entry drained.
- Key 10 held through `RST` release → no event. `RST` asserted mid-REPEAT with 2 entries queued → next cycle `count=0`, `ev_valid=0`, no further repeats while still held.
